// File: rtl/memory_loader.sv
// Host-side burst write engine for the CGRA data memory: takes (address, length)
// commands plus a data stream and issues one memory write per accepted word.
// Optional running checksum of written data: define MEMORY_LOADER_CHECKSUM_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; the loader never looks at valid to decide ready, and ignores valid while
// its ready is low (stray commands and data are dropped, not queued).
module memory_loader #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int MEMORY_SIZE   = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_address,
  input  logic [ADDRESS_WIDTH-1:0] cmd_length,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic                     write,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
`ifdef MEMORY_LOADER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0]    checksum,
`endif
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One extra bit so MEMORY_SIZE == 2**ADDRESS_WIDTH still compares correctly.
  localparam logic [ADDRESS_WIDTH:0]   C_MEM_SIZE  = (ADDRESS_WIDTH+1)'(MEMORY_SIZE);
  localparam logic [ADDRESS_WIDTH-1:0] C_LAST_ADDR = ADDRESS_WIDTH'(MEMORY_SIZE - 1);
  localparam logic [ADDRESS_WIDTH-1:0] C_ONE       = ADDRESS_WIDTH'(1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH-1:0] r_remaining;
  logic                     r_error;
  logic                     r_write;
  logic [ADDRESS_WIDTH-1:0] r_write_address;
  logic [DATA_WIDTH-1:0]    r_write_data;

  logic                     w_cmd_fire;
  logic                     w_cmd_reject;
  logic                     w_beat;
  logic [ADDRESS_WIDTH-1:0] w_addr_next;

  assign w_addr_next = (r_addr == C_LAST_ADDR) ? '0 : r_addr + C_ONE;

  always_comb begin
    w_state_next = r_state;
    w_cmd_fire   = 1'b0;
    w_cmd_reject = 1'b0;
    w_beat       = 1'b0;
    cmd_ready    = 1'b0;
    data_ready   = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_cmd_fire = 1'b1;
          if ({1'b0, cmd_address} >= C_MEM_SIZE) begin
            w_cmd_reject = 1'b1;
            w_state_next = ST_DONE;
          end else if (cmd_length == '0) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        data_ready = 1'b1;
        if (data_valid) begin
          w_beat = 1'b1;
          if (r_remaining == C_ONE) w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        error        = r_error;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr          <= '0;
      r_remaining     <= '0;
      r_error         <= 1'b0;
      r_write         <= 1'b0;
      r_write_address <= '0;
      r_write_data    <= '0;
    end else begin
      r_write <= w_beat;
      if (w_cmd_fire) begin
        r_addr      <= cmd_address;
        r_remaining <= cmd_length;
        r_error     <= w_cmd_reject;
      end
      // Beats only occur in LOAD, so they never collide with a command fire.
      if (w_beat) begin
        r_write_address <= r_addr;
        r_write_data    <= data_in;
        r_addr          <= w_addr_next;
        r_remaining     <= r_remaining - C_ONE;
      end
    end
  end

`ifdef MEMORY_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  // Accumulated at beat time so the sum already includes the write it is paired with.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_checksum <= '0;
    end else if (w_cmd_fire) begin
      r_checksum <= '0;
    end else if (w_beat) begin
      r_checksum <= r_checksum + data_in;
    end
  end

  assign checksum = r_checksum;
`endif

  assign write         = r_write;
  assign write_address = r_write_address;
  assign write_data    = r_write_data;
  assign dbg_state     = r_state;

  a_write_follows_load: assert property (
    @(posedge clk) disable iff (!reset_n) r_write |-> $past(r_state) == ST_LOAD);

  a_load_has_words: assert property (
    @(posedge clk) disable iff (!reset_n) (r_state == ST_LOAD) |-> (r_remaining != '0));

endmodule

// File: tb/tb_memory_loader.sv
// Directed bench for memory_loader: a transaction-level model (expected write
// queue, done/error counts, running sum) checked on every cycle, plus literals.
module tb_memory_loader;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int MEM = 1024;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_address;
  logic [AW-1:0] cmd_length;
  logic          data_valid;
  logic          data_ready;
  logic [DW-1:0] data_in;
  logic          write;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    dbg_state;
`ifdef MEMORY_LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  memory_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEMORY_SIZE(MEM)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_address  (cmd_address),
    .cmd_length   (cmd_length),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .data_in      (data_in),
    .write        (write),
    .write_address(write_address),
    .write_data   (write_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
`ifdef MEMORY_LOADER_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- model state ----------------
  logic [AW+DW-1:0] exp_q[$];
  int               m_addr = 0;
  logic [DW-1:0]    m_sum = '0;
  int               exp_done = 0;
  int               exp_err = 0;
  int               done_seen = 0;
  int               err_seen = 0;
  int               writes_seen = 0;
  logic [AW-1:0]    last_a = '0;
  logic [DW-1:0]    last_d = '0;
  bit               rst_at_edge = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(posedge clk) rst_at_edge = !reset_n;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_data_ready", data_ready, 0);
      check("rst_write", write, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_waddr", write_address, 0);
      check("rst_wdata", write_data, 0);
      last_a = '0;
      last_d = '0;
      exp_q.delete();
    end else begin
      check("ready_vs_busy", cmd_ready, !busy);
      check("data_ready_in_done", data_ready & done, 0);
      check("done_implies_busy", done & !busy, 0);
      check("error_without_done", error & !done, 0);
      if (write) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write at %0t",
                   write_address, write_data, $time);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_q.pop_front();
          check("write_addr", write_address, e[AW+DW-1:DW]);
          check("write_data", write_data, e[DW-1:0]);
        end
        last_a = write_address;
        last_d = write_data;
      end else begin
        check("hold_addr", write_address, last_a);
        check("hold_data", write_data, last_d);
      end
      if (done)  done_seen++;
      if (error) err_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int addr, input int len, input bit keep_valid);
    int t;
    cmd_address = AW'(addr);
    cmd_length  = AW'(len);
    cmd_valid   = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin
      step();
      t++;
    end
    check("cmd_accept_timeout", cmd_ready, 1);
    step();
    if (!keep_valid) cmd_valid = 1'b0;
    m_addr = addr;
    m_sum  = '0;
    exp_done++;
    if (addr >= MEM) exp_err++;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit gap_after);
    int t;
    data_in    = d;
    data_valid = 1'b1;
    t = 0;
    while (!data_ready && t < 50) begin
      step();
      t++;
    end
    check("beat_timeout", data_ready, 1);
    step();
    exp_q.push_back({AW'(m_addr), d});
    m_addr = (m_addr + 1) % MEM;
    m_sum  = m_sum + d;
    if (gap_after) begin
      data_valid = 1'b0;
      step();
      check("gap_write", write, 0);
    end
  endtask

  task automatic check_sum(input string name, input logic [DW-1:0] exp);
`ifdef MEMORY_LOADER_CHECKSUM_EN
    check(name, checksum, exp);
`else
    if (exp === 'x) $display("unused %s", name);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    int d0;
    reset_n     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_address = '0;
    cmd_length  = '0;
    data_valid  = 1'b0;
    data_in     = '0;
    step();
    step();
    reset_n = 1'b1;
    check("reset_state", dbg_state, 0);
    check_sum("reset_checksum", 0);

    // 1: basic burst
    send_cmd(5, 3, 0);
    check("t1_busy", busy, 1);
    check("t1_load", dbg_state, 1);
    send_beat(32'hA, 0);
    check("t1_first_addr", write_address, 5);
    send_beat(32'hB, 0);
    send_beat(32'hC, 0);
    data_valid = 1'b0;
    check("t1_done", done, 1);
    check("t1_error", error, 0);
    check("t1_last_write", write, 1);
    check("t1_last_addr", write_address, 7);
    check("t1_last_data", write_data, 32'hC);
    check_sum("t1_checksum", 32'h21);
    check_sum("t1_checksum_model", m_sum);
    step();
    check("t1_busy_fall", busy, 0);
    check("t1_cmd_ready", cmd_ready, 1);

    // 2: wrap-around with gaps (valid pattern 1,0,1,1,0,1)
    send_cmd(MEM - 2, 4, 0);
    send_beat(32'h100, 1);
    check("t2_addr0", write_address, 1022);
    send_beat(32'h101, 0);
    check("t2_addr1", write_address, 1023);
    send_beat(32'h102, 1);
    check("t2_addr2_held", write_address, 0);
    send_beat(32'h103, 0);
    data_valid = 1'b0;
    check("t2_addr3", write_address, 1);
    check("t2_done", done, 1);
    check_sum("t2_checksum", 32'h406);
    step();

    // 3: zero length
    send_cmd(10, 0, 0);
    check("t3_done", done, 1);
    check("t3_error", error, 0);
    check("t3_write", write, 0);
    check("t3_data_ready", data_ready, 0);
    check_sum("t3_checksum", 0);
    step();
    check("t3_cmd_ready", cmd_ready, 1);

    // 4: rejected address with data on offer
    data_in    = 32'hBAD;
    data_valid = 1'b1;
    send_cmd(MEM, 2, 0);
    check("t4_done", done, 1);
    check("t4_error", error, 1);
    check("t4_data_ready", data_ready, 0);
    check("t4_write", write, 0);
    step();
    check("t4_cmd_ready", cmd_ready, 1);
    check("t4_idle_data_ready", data_ready, 0);
    data_valid = 1'b0;
    step();

    // 5: reset mid-burst
    w0 = writes_seen;
    d0 = done_seen;
    send_cmd(300, 8, 0);
    send_beat(32'h11, 0);
    send_beat(32'h22, 0);
    send_beat(32'h33, 0);
    check("t5_third_write", write, 1);
    check("t5_third_addr", write_address, 302);
    reset_n = 1'b0;
    step();
    reset_n    = 1'b1;
    data_valid = 1'b0;
    exp_done--;
    m_sum = '0;
    check("t5_idle_after_reset", dbg_state, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    step();
    step();
    check("t5_write_count", writes_seen - w0, 3);
    check("t5_no_done", done_seen - d0, 0);
    send_cmd(0, 1, 0);
    send_beat(32'h55, 0);
    data_valid = 1'b0;
    check("t5_new_done", done, 1);
    check("t5_new_addr", write_address, 0);
    check_sum("t5_checksum", 32'h55);
    step();

    // 6: stray handshake inputs
    w0         = writes_seen;
    data_in    = 32'h77;
    data_valid = 1'b1;
    repeat (3) step();
    data_valid = 1'b0;
    check("t6_idle_no_write", writes_seen - w0, 0);
    check("t6_still_idle", busy, 0);
    send_cmd(100, 2, 1);
    cmd_address = AW'(200);
    cmd_length  = AW'(5);
    send_beat(32'h1, 0);
    send_beat(32'h2, 0);
    data_valid = 1'b0;
    check("t6_done", done, 1);
    check("t6_last_addr", write_address, 101);
    cmd_valid = 1'b0;
    step();
    check("t6_idle", busy, 0);
    step();
    check("t6_no_second_cmd", busy, 0);
    check("t6_write_count", writes_seen - w0, 2);

    step();
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_done_count", done_seen, exp_done);
    check("final_error_count", err_seen, exp_err);
    check("final_done_total", done_seen, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
